// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Holds the ALU request and buffered-load entry layouts plus a small port-use helper.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } ld_entry_t;

    // An ALU result only occupies a write port when it targets a real register.
    function automatic logic wb_active(input wb_req_t req);
        return req.valid && (req.rd != '0);
    endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// Load-result FIFO: push one per cycle, pop up to two per cycle from the head.
// Latency: pushed entry is visible at the head on the following cycle.
// Backpressure: ready_o low while full or in reset; stale entries are killed in place.
module wb_ld_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_rd_i,
    input  logic [XLEN-1:0]       push_data_i,
    input  logic                  kill_a_vld_i,
    input  logic [REG_ADDR_W-1:0] kill_a_rd_i,
    input  logic                  kill_b_vld_i,
    input  logic [REG_ADDR_W-1:0] kill_b_rd_i,
    input  logic [1:0]            pop_cnt_i,
    output ld_entry_t             head0_o,
    output logic                  head0_vld_o,
    output ld_entry_t             head1_o,
    output logic                  head1_vld_o,
    output logic                  ready_o
`ifdef WB_PERF_EN
    ,
    output logic [$clog2(DEPTH):0] kill_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ld_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] kill;
    logic [PTR_W-1:0] head1_idx;
    logic             push_hit;
    ld_entry_t        push_entry;

    function automatic logic stale_hit(input logic [REG_ADDR_W-1:0] rd,
                                       input logic a_vld, input logic [REG_ADDR_W-1:0] a_rd,
                                       input logic b_vld, input logic [REG_ADDR_W-1:0] b_rd);
        return (a_vld && (a_rd == rd)) || (b_vld && (b_rd == rd));
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] offs;
        assign offs    = PTR_W'(g) - rd_ptr_q;
        assign occ[g]  = {1'b0, offs} < count_q;
        assign kill[g] = occ[g] && mem_q[g].live &&
                         stale_hit(mem_q[g].rd, kill_a_vld_i, kill_a_rd_i, kill_b_vld_i, kill_b_rd_i);
    end

    // Loads are older than same-cycle ALU results, so an incoming load can be born dead.
    assign push_hit   = stale_hit(push_rd_i, kill_a_vld_i, kill_a_rd_i, kill_b_vld_i, kill_b_rd_i);
    assign push_entry = '{live: (push_rd_i != '0) && !push_hit, rd: push_rd_i, data: push_data_i};

    assign head1_idx = rd_ptr_q + PTR_W'(1);

    always_comb begin
        head0_o      = mem_q[rd_ptr_q];
        head0_o.live = mem_q[rd_ptr_q].live && !kill[rd_ptr_q];
        head1_o      = mem_q[head1_idx];
        head1_o.live = mem_q[head1_idx].live && !kill[head1_idx];
    end

    assign head0_vld_o = count_q != '0;
    assign head1_vld_o = count_q > CNT_W'(1);
    assign ready_o     = !reset && (count_q < CNT_W'(DEPTH));

    assign count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_cnt_i);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt_i);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push_i);

`ifdef WB_PERF_EN
    always_comb begin
        kill_cnt_o = CNT_W'(push_i && push_hit && (push_rd_i != '0));
        for (int i = 0; i < DEPTH; i++) begin
            kill_cnt_o = kill_cnt_o + CNT_W'(kill[i]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is derived from pointers and count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (kill[i]) begin
                mem_q[i].live <= 1'b0;
            end
        end
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU slots A/B and buffered loads onto register-file write ports 3 and 6 (optional WB_PERF_EN counters).
// Latency: ALU 1 cycle, loads >= 2 cycles. Backpressure: ALU never stalls; ld_ready drops when FIFO full.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            we6,
    output logic [4:0]      a6,
    output logic [XLEN-1:0] wd6
`ifdef WB_PERF_EN
    ,
    output logic [15:0]     perf_ld_stall,
    output logic [15:0]     perf_stale_kill
`endif
);

    import regfile_pkg::*;

    wb_req_t         req_a, req_b;
    logic            port3_busy, port6_busy;
    logic            push;
    ld_entry_t       head0, head1;
    logic            head0_vld, head1_vld;
    ld_entry_t       heads [2];
    logic [1:0]      heads_vld;
    logic [1:0]      pop_cnt;
    logic            free3, free6, blocked;
    logic            we3_d, we6_d, we3_q, we6_q;
    logic [4:0]      a3_d, a6_d, a3_q, a6_q;
    logic [XLEN-1:0] wd3_d, wd6_d, wd3_q, wd6_q;

    assign req_a      = '{valid: a_valid, rd: a_rd, data: a_data};
    assign req_b      = '{valid: b_valid, rd: b_rd, data: b_data};
    assign port3_busy = wb_active(req_a);
    assign port6_busy = wb_active(req_b);
    assign push       = ld_valid && ld_ready;

`ifdef WB_PERF_EN
    logic [$clog2(DEPTH):0] kill_cnt;
`endif

    wb_ld_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_rd_i    (ld_rd),
        .push_data_i  (ld_data),
        .kill_a_vld_i (port3_busy),
        .kill_a_rd_i  (a_rd),
        .kill_b_vld_i (port6_busy),
        .kill_b_rd_i  (b_rd),
        .pop_cnt_i    (pop_cnt),
        .head0_o      (head0),
        .head0_vld_o  (head0_vld),
        .head1_o      (head1),
        .head1_vld_o  (head1_vld),
        .ready_o      (ld_ready)
`ifdef WB_PERF_EN
        ,
        .kill_cnt_o   (kill_cnt)
`endif
    );

    assign heads[0]  = head0;
    assign heads[1]  = head1;
    assign heads_vld = {head1_vld, head0_vld};

    // In-order drain: dead heads pop for free, a live head that finds no port blocks the rest.
    always_comb begin
        we3_d   = port3_busy;
        a3_d    = port3_busy ? req_a.rd : '0;
        wd3_d   = port3_busy ? req_a.data : '0;
        we6_d   = port6_busy;
        a6_d    = port6_busy ? req_b.rd : '0;
        wd6_d   = port6_busy ? req_b.data : '0;
        free3   = !port3_busy;
        free6   = !port6_busy;
        blocked = 1'b0;
        pop_cnt = 2'd0;
        for (int k = 0; k < 2; k++) begin
            if (heads_vld[k] && !blocked) begin
                if (!heads[k].live) begin
                    pop_cnt = pop_cnt + 2'd1;
                end else if (free3) begin
                    we3_d   = 1'b1;
                    a3_d    = heads[k].rd;
                    wd3_d   = heads[k].data;
                    free3   = 1'b0;
                    pop_cnt = pop_cnt + 2'd1;
                end else if (free6) begin
                    we6_d   = 1'b1;
                    a6_d    = heads[k].rd;
                    wd6_d   = heads[k].data;
                    free6   = 1'b0;
                    pop_cnt = pop_cnt + 2'd1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
            we6_q <= 1'b0;
            a6_q  <= '0;
            wd6_q <= '0;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
            we6_q <= we6_d;
            a6_q  <= a6_d;
            wd6_q <= wd6_d;
        end
    end

    assign we3 = we3_q;
    assign a3  = a3_q;
    assign wd3 = wd3_q;
    assign we6 = we6_q;
    assign a6  = a6_q;
    assign wd6 = wd6_q;

`ifdef WB_PERF_EN
    logic [15:0] ld_stall_q, stale_kill_q;
    logic [16:0] stale_sum;

    assign stale_sum = {1'b0, stale_kill_q} + 17'(kill_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_stall_q   <= '0;
            stale_kill_q <= '0;
        end else begin
            if (ld_valid && !ld_ready && (ld_stall_q != 16'hFFFF)) begin
                ld_stall_q <= ld_stall_q + 16'd1;
            end
            stale_kill_q <= stale_sum[16] ? 16'hFFFF : stale_sum[15:0];
        end
    end

    assign perf_ld_stall   = ld_stall_q;
    assign perf_stale_kill = stale_kill_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed write-port expectations per cycle.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid, ld_valid;
    logic [4:0]  a_rd, b_rd, ld_rd;
    logic [31:0] a_data, b_data, ld_data;
    logic        ld_ready;
    logic        we3, we6;
    logic [4:0]  a3, a6;
    logic [31:0] wd3, wd6;
`ifdef WB_PERF_EN
    logic [15:0] perf_ld_stall, perf_stale_kill;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    regfile_wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_rd     (a_rd),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_rd     (b_rd),
        .b_data   (b_data),
        .ld_valid (ld_valid),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .we3      (we3),
        .a3       (a3),
        .wd3      (wd3),
        .we6      (we6),
        .a6       (a6),
        .wd6      (wd6)
`ifdef WB_PERF_EN
        ,
        .perf_ld_stall   (perf_ld_stall),
        .perf_stale_kill (perf_stale_kill)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
    endtask

    task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        ld_valid = v; ld_rd = rd; ld_data = d;
    endtask

    task automatic idle();
        alu(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        ld(1'b0, 5'd0, 32'h0);
    endtask

    task automatic busy();
        alu(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ld(1'b1, 5'd3, 32'h33);

        // Reset with a load offered
        step();
        step();
        check("rst_ld_ready", ld_ready, 0);
        check("rst_we3", we3, 0);
        check("rst_we6", we6, 0);
        check("rst_a3", a3, 0);
        check("rst_wd6", wd6, 0);
        reset = 1'b0;
        idle();
        #1;
        check("post_rst_ld_ready", ld_ready, 1);
        step();
        check("post_rst_we3", we3, 0);

        // Both ALU slots to the same register
        alu(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        step();
        idle();
        check("alu_we3", we3, 1);
        check("alu_a3", a3, 5);
        check("alu_wd3", wd3, 32'h11);
        check("alu_we6", we6, 1);
        check("alu_a6", a6, 5);
        check("alu_wd6", wd6, 32'h22);

        // Single load, minimum latency 2
        ld(1'b1, 5'd7, 32'hAB);
        step();
        idle();
        check("ld_n1_we3", we3, 0);
        step();
        check("ld_we3", we3, 1);
        check("ld_a3", a3, 7);
        check("ld_wd3", wd3, 32'hAB);
        check("ld_we6", we6, 0);

        // rd==0 ALU result is dropped
        alu(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        check("x0_we3", we3, 0);
        check("x0_we6", we6, 0);

        // Fill FIFO behind busy ports, then drain two per cycle
        for (int k = 0; k < 4; k++) begin
            busy();
            ld(1'b1, 5'(10 + k), 32'hA0 + k);
            #1;
            check("fill_ready", ld_ready, 1);
            step();
        end
        busy();
        ld(1'b1, 5'd14, 32'hA4);
        #1;
        check("full_ready", ld_ready, 0);
        step();
        check("full_ready2", ld_ready, 0);
        check("full_alu_a3", a3, 1);
        check("full_alu_a6", a6, 2);
        idle();
        step();
        check("drain1_a3", a3, 10);
        check("drain1_wd3", wd3, 32'hA0);
        check("drain1_we6", we6, 1);
        check("drain1_a6", a6, 11);
        check("drain1_wd6", wd6, 32'hA1);
        check("drain1_ready", ld_ready, 1);
        step();
        check("drain2_a3", a3, 12);
        check("drain2_wd3", wd3, 32'hA2);
        check("drain2_a6", a6, 13);
        check("drain2_wd6", wd6, 32'hA3);
        step();
        check("drain3_we3", we3, 0);
        check("drain3_we6", we6, 0);

        // Dead head pops for free; next live entry takes port 6 while port 3 is busy
        busy();
        ld(1'b1, 5'd0, 32'h01);
        step();
        ld(1'b1, 5'd4, 32'h41);
        step();
        ld(1'b1, 5'd4, 32'h42);
        step();
        idle();
        alu(1'b1, 5'd1, 32'h5A, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        check("dead_a3", a3, 1);
        check("dead_wd3", wd3, 32'h5A);
        check("dead_we6", we6, 1);
        check("dead_a6", a6, 4);
        check("dead_wd6", wd6, 32'h41);
        step();
        check("dead2_we3", we3, 1);
        check("dead2_wd3", wd3, 32'h42);
        check("dead2_we6", we6, 0);
        step();
        check("dead3_we3", we3, 0);

        // Buffered load killed by a newer ALU write to the same register
        busy();
        ld(1'b1, 5'd9, 32'h99);
        step();
        idle();
        alu(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        check("stale_a3", a3, 9);
        check("stale_wd3", wd3, 32'h55);
        check("stale_we6", we6, 0);
        step();
        check("stale_after_we3", we3, 0);
        check("stale_after_we6", we6, 0);

        // Load and ALU write to the same register in the same cycle
        alu(1'b1, 5'd9, 32'h66, 1'b0, 5'd0, 32'h0);
        ld(1'b1, 5'd9, 32'h77);
        step();
        idle();
        check("same_wd3", wd3, 32'h66);
        check("same_we6", we6, 0);
        step();
        check("same_after_we3", we3, 0);
        check("same_after_we6", we6, 0);

        // Reset discards buffered loads
        for (int k = 0; k < 3; k++) begin
            busy();
            ld(1'b1, 5'(20 + k), 32'hC0 + k);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        check("mid_rst_we3", we3, 0);
        check("mid_rst_we6", we6, 0);
        check("mid_rst_ready", ld_ready, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready_rel", ld_ready, 1);
        step();
        check("mid_rst_we3_a", we3, 0);
        check("mid_rst_we6_a", we6, 0);
        step();
        check("mid_rst_we3_b", we3, 0);
        check("mid_rst_we6_b", we6, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
